fifo_rd_streamer: RTL



---
 rtl/fifo_rd_streamer_pkg.sv | 15 +
 rtl/fifo_rd_streamer_skid_buf.sv | 65 ++++++
 rtl/fifo_rd_streamer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// Shared types and default constants for the FIFO read-side streamer.
// Optional build macro: FIFO_RD_STREAMER_STATS_EN (stall/starve statistics ports).
package fifo_rd_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } streamer_state_e;

    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned PKT_LEN_DEF    = 8;
    localparam int unsigned SKID_DEPTH_DEF = 2;

endpackage

// File: rtl/fifo_rd_streamer_skid_buf.sv
// Circular skid buffer: DEPTH entries of data plus a per-entry last tag.
// Head is presented combinationally; push writes the tail, pop advances the head.
module stream_skid_buf
    import fifo_rd_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = SKID_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         push_last,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_last,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_data = data_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];

    // Storage, pointers and occupancy; storage cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
            end
            last_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Reads are only issued when there is room, so the buffer can never overfill.
    assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a FIFO with one-cycle registered read latency and presents the words
// as a valid/ready stream with m_last every PKT_LEN accepted beats.
// Optional build macro: FIFO_RD_STREAMER_STATS_EN adds stall_cnt/starve_cnt.
module fifo_rd_streamer
    import fifo_rd_streamer_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned PKT_LEN    = PKT_LEN_DEF,
    parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush,
    output logic                  busy
`ifdef FIFO_RD_STREAMER_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           starve_cnt
`endif
);

    localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned SW = BW + CW + 1;

    streamer_state_e state;
    streamer_state_e state_nxt;

    logic [CW-1:0] count;
    logic          inflight;
    logic [BW-1:0] beat_cnt;
    logic          pop;
    logic          rd_issue;
    logic          head_last;
    logic          push_last;
    logic          flush_final;
    logic [CW:0]   occ;
    logic [SW-1:0] tail_idx;

    assign pop     = m_valid & m_ready;
    assign m_valid = (count != '0);
    assign busy    = (state != IDLE);

    // Occupancy after this cycle's pop, counting the word still in flight from the FIFO.
    assign occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign rd_issue = rst_n & ~fifo_empty & ~flush & (state != FLUSH)
                    & (occ < (CW+1)'(SKID_DEPTH));
    assign fifo_rd_en = rd_issue;

    // The captured word lands count entries behind the head, so its packet position is
    // beat_cnt + count; tagging it on capture keeps the head's m_last a plain lookup.
    assign tail_idx  = SW'(beat_cnt) + SW'(count);
    assign push_last = ((tail_idx % SW'(PKT_LEN)) == SW'(PKT_LEN - 1));

    // Closing beat of a flush terminates an open packet early.
    assign flush_final = (state == FLUSH) & (count == CW'(1)) & ~inflight & (beat_cnt != '0);
    assign m_last      = m_valid & (head_last | flush_final);

    stream_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data_out),
        .push_last (push_last),
        .pop       (pop),
        .head_data (m_data),
        .head_last (head_last),
        .count     (count)
    );

    // State register and the in-flight read marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_issue;
        end
    end

    // Next-state: stream while reading, flush drains the skid before returning idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_issue) state_nxt = STREAM;
            end
            STREAM: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if ((count == '0) && !inflight && !rd_issue) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if ((count == '0) && !inflight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat position within the packet; survives starvation, cleared when a flush completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if ((state == FLUSH) && (state_nxt == IDLE)) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= m_last ? '0 : beat_cnt + BW'(1);
        end
    end

`ifdef FIFO_RD_STREAMER_STATS_EN
    // Saturating counts of backpressure stalls and starved streaming cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (m_valid && !m_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((state == STREAM) && !m_valid && (starve_cnt != '1)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
